operand_join_adder_stage: RTL and testbench

- Pipelined join-and-add stage between the two operand deserializers and the result serializer in the serial adder datapath.
- Accepts one DATA_WIDTH word per operand over independent valid/ready handshakes and holds each operand until its partner arrives.
- Adds each operand pair with carry-in and queues the (sum, cout) result in a 2-entry output FIFO.
- Presents the FIFO head to the serializer over a valid/ready handshake. Sustains one result per cycle.

---
 rtl/operand_join_adder_stage.sv | 96 +++++++++
 tb/tb_operand_join_adder_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/operand_join_adder_stage.sv
// Joins one A word (with carry-in) and one B word, adds them, and queues
// {cout, sum} in a 2-entry FIFO drained over a valid/ready handshake.
module operand_join_adder_stage #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] iv_a,
    input  logic                  i_cin,
    input  logic                  i_a_valid,
    output logic                  o_a_ready,
    input  logic [DATA_WIDTH-1:0] iv_b,
    input  logic                  i_b_valid,
    output logic                  o_b_ready,
    output logic [DATA_WIDTH-1:0] ov_sum,
    output logic                  o_cout,
    output logic                  o_sum_valid,
    input  logic                  i_ready
);

    logic                  r_a_full;
    logic                  r_b_full;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic                  r_cin;
    logic [DATA_WIDTH:0]   r_mem [0:1];
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [1:0]            r_count;

    logic                  w_do_combine;
    logic                  w_pop;
    logic                  w_a_hs;
    logic                  w_b_hs;
    logic [DATA_WIDTH:0]   w_sum;

    // Combine depends on registered state only, so i_ready never reaches the input readies.
    assign w_do_combine = i_en & r_a_full & r_b_full & (r_count != 2'd2);
    assign o_a_ready    = ~i_rst & i_en & (~r_a_full | w_do_combine);
    assign o_b_ready    = ~i_rst & i_en & (~r_b_full | w_do_combine);
    assign w_a_hs       = i_a_valid & o_a_ready;
    assign w_b_hs       = i_b_valid & o_b_ready;

    assign w_sum = {1'b0, r_a} + {1'b0, r_b} + {{DATA_WIDTH{1'b0}}, r_cin};

    assign o_sum_valid      = (r_count != 2'd0);
    assign {o_cout, ov_sum} = r_mem[r_rd_ptr];
    assign w_pop            = o_sum_valid & i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a_full <= 1'b0;
            r_b_full <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_cin    <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_a_hs) begin
                r_a      <= iv_a;
                r_cin    <= i_cin;
                r_a_full <= 1'b1;
            end else if (w_do_combine) begin
                r_a_full <= 1'b0;
            end

            if (w_b_hs) begin
                r_b      <= iv_b;
                r_b_full <= 1'b1;
            end else if (w_do_combine) begin
                r_b_full <= 1'b0;
            end

            if (w_do_combine) begin
                r_mem[r_wr_ptr] <= w_sum;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end

            case ({w_do_combine, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_join_adder_stage.sv
// Bench for operand_join_adder_stage: queue-based reference model checked every
// cycle, plus directed cases with literal expected values.
module tb_operand_join_adder_stage;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [DW-1:0] a_d;
    logic          cin_d;
    logic          a_valid;
    logic          a_ready;
    logic [DW-1:0] b_d;
    logic          b_valid;
    logic          b_ready;
    logic [DW-1:0] sum;
    logic          cout;
    logic          sum_valid;
    logic          rdy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;
    logic a_fire = 1'b0;
    logic b_fire = 1'b0;

    logic [DW:0]   qa [$];
    logic [DW-1:0] qb [$];
    logic [DW:0]   qf [$];

    always #5 clk = ~clk;

    operand_join_adder_stage #(.DATA_WIDTH(DW)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .iv_a        (a_d),
        .i_cin       (cin_d),
        .i_a_valid   (a_valid),
        .o_a_ready   (a_ready),
        .iv_b        (b_d),
        .i_b_valid   (b_valid),
        .o_b_ready   (b_ready),
        .ov_sum      (sum),
        .o_cout      (cout),
        .o_sum_valid (sum_valid),
        .i_ready     (rdy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: one-deep operand holds and a 2-deep result queue.
    always @(negedge clk) begin
        logic          comb;
        logic          exp_ar;
        logic          exp_br;
        logic [DW:0]   ea;
        logic [DW-1:0] eb;
        logic [DW:0]   s;
        comb   = en && !rst && qa.size() > 0 && qb.size() > 0 && qf.size() < 2;
        exp_ar = !rst && en && (qa.size() == 0 || comb);
        exp_br = !rst && en && (qb.size() == 0 || comb);
        chk("a_ready", {31'b0, a_ready}, {31'b0, exp_ar});
        chk("b_ready", {31'b0, b_ready}, {31'b0, exp_br});
        chk("sum_valid", {31'b0, sum_valid}, {31'b0, qf.size() != 0});
        if (qf.size() != 0)
            chk("head", {15'b0, cout, sum}, {15'b0, qf[0]});
        a_fire = a_valid && a_ready;
        b_fire = b_valid && b_ready;
        if (sum_valid && rdy) n_out++;
        if (rst) begin
            qa.delete();
            qb.delete();
            qf.delete();
        end else begin
            if (qf.size() != 0 && rdy) void'(qf.pop_front());
            if (comb) begin
                ea = qa.pop_front();
                eb = qb.pop_front();
                s  = {1'b0, ea[DW-1:0]} + {1'b0, eb} + {{DW{1'b0}}, ea[DW]};
                qf.push_back(s);
            end
            if (a_valid && exp_ar) qa.push_back({cin_d, a_d});
            if (b_valid && exp_br) qb.push_back(b_d);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd();
        case ($urandom % 6)
            0:       rnd = '0;
            1:       rnd = '1;
            2:       rnd = 16'h8000;
            3:       rnd = 16'h0001;
            default: rnd = DW'($urandom);
        endcase
    endfunction

    // Holds each offered word until it is accepted; launches at most maxp new words per side.
    task automatic run(input int cycles, input int pv, input int pr, input int pe, input int maxp);
        int na = 0;
        int nb = 0;
        for (int c = 0; c < cycles; c++) begin
            tick();
            if (!a_valid || a_fire) begin
                if (na < maxp && $urandom_range(99) < pv) begin
                    a_valid = 1'b1; a_d = rnd(); cin_d = 1'($urandom); na++;
                end else a_valid = 1'b0;
            end
            if (!b_valid || b_fire) begin
                if (nb < maxp && $urandom_range(99) < pv) begin
                    b_valid = 1'b1; b_d = rnd(); nb++;
                end else b_valid = 1'b0;
            end
            rdy = $urandom_range(99) < pr;
            en  = $urandom_range(99) < pe;
        end
    endtask

    task automatic pair_lit(input logic [DW-1:0] a, input logic c, input logic [DW-1:0] b,
                            input logic [DW-1:0] es, input logic ec);
        tick();
        a_d = a; cin_d = c; b_d = b; a_valid = 1'b1; b_valid = 1'b1;
        chk("pair_a_ready", {31'b0, a_ready}, 32'd1);
        chk("pair_b_ready", {31'b0, b_ready}, 32'd1);
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        chk("pair_n1_valid", {31'b0, sum_valid}, 32'd0);
        tick();
        chk("pair_n2_valid", {31'b0, sum_valid}, 32'd1);
        chk("pair_sum", {16'b0, sum}, {16'b0, es});
        chk("pair_cout", {31'b0, cout}, {31'b0, ec});
        tick();
        chk("pair_n3_valid", {31'b0, sum_valid}, 32'd0);
    endtask

    initial begin
        int base;
        rst = 1'b1; en = 1'b1; rdy = 1'b1;
        a_d = '0; b_d = '0; cin_d = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        repeat (3) tick();
        chk("rst_a_ready", {31'b0, a_ready}, 32'd0);
        chk("rst_b_ready", {31'b0, b_ready}, 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_valid", {31'b0, sum_valid}, 32'd0);
        chk("post_rst_sum", {15'b0, cout, sum}, 32'd0);

        pair_lit(16'h0003, 1'b0, 16'h0004, 16'h0007, 1'b0);
        pair_lit(16'hFFFF, 1'b1, 16'h0001, 16'h0001, 1'b1);
        pair_lit(16'h8000, 1'b0, 16'h8000, 16'h0000, 1'b1);

        // A arrives four cycles before B; a second A waits for the combine.
        tick(); a_valid = 1'b1; a_d = 16'h0010; cin_d = 1'b0;
        chk("stag_c0", {31'b0, a_ready}, 32'd1);
        tick(); a_valid = 1'b0;
        chk("stag_c1", {31'b0, a_ready}, 32'd0);
        tick(); a_valid = 1'b1; a_d = 16'h0020;
        chk("stag_c2", {31'b0, a_ready}, 32'd0);
        tick();
        chk("stag_c3", {31'b0, a_ready}, 32'd0);
        tick(); b_valid = 1'b1; b_d = 16'h0005;
        chk("stag_c4", {31'b0, a_ready}, 32'd0);
        tick(); b_valid = 1'b0;
        chk("stag_c5", {31'b0, a_ready}, 32'd1);
        chk("stag_c5_valid", {31'b0, sum_valid}, 32'd0);
        tick(); a_valid = 1'b0;
        chk("stag_c6_valid", {31'b0, sum_valid}, 32'd1);
        chk("stag_c6_sum", {16'b0, sum}, 32'h0015);
        tick(); b_valid = 1'b1; b_d = 16'h0007;
        tick(); b_valid = 1'b0;
        tick();
        chk("stag_c9_sum", {15'b0, cout, sum}, 32'h0027);
        tick();

        base = n_out;
        run(14, 100, 100, 100, 8);
        chk("stream_count", n_out - base, 32'd8);

        base = n_out;
        run(10, 100, 0, 100, 4);
        chk("bp_a_ready", {31'b0, a_ready}, 32'd0);
        chk("bp_b_ready", {31'b0, b_ready}, 32'd0);
        chk("bp_valid", {31'b0, sum_valid}, 32'd1);
        run(12, 0, 100, 100, 0);
        chk("bp_drain_count", n_out - base, 32'd4);
        chk("bp_drain_empty", {31'b0, sum_valid}, 32'd0);

        run(10, 100, 0, 100, 4);
        tick(); rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; rdy = 1'b1;
        tick(); rst = 1'b0;
        chk("mid_rst_valid", {31'b0, sum_valid}, 32'd0);
        chk("mid_rst_head", {15'b0, cout, sum}, 32'd0);
        pair_lit(16'h0005, 1'b0, 16'h0006, 16'h000B, 1'b0);

        run(1500, 70, 60, 85, 100000);
        run(40, 0, 100, 100, 0);
        a_valid = 1'b0; b_valid = 1'b0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
